kim_stream_checker: RTL and testbench

Synthesizable valid/ready stream receiver and checker. Sits at the output side of the FIFO/skid-buffer datapath, where the bench's output model used to be. It accepts a fixed number of beats with either constant or pseudo-random backpressure and checks that they form the incrementing sequence 0, 1, 2, …. It reports progress, the mismatch count and the first mismatch, so FIFO stress runs can execute on silicon or FPGA without a file dump.

---
 rtl/kim_stream_checker.sv | 125 ++++++++++++
 tb/tb_kim_stream_checker.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/kim_stream_checker.sv
// Valid/ready stream sink that checks incoming beats against an incrementing
// sequence. It records progress, mismatch count and the first mismatch for on-chip FIFO stress runs.
module kim_stream_checker #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TEST_NUM   = 16,
  parameter bit          READY_MODE = 1'b1,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_run,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic [31:0]           o_rx_cnt,
  output logic [15:0]           o_err_cnt,
  output logic [31:0]           o_first_err_idx,
  output logic [DATA_WIDTH-1:0] o_first_err_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // An all-zero seed would lock the LFSR, so it is remapped.
  localparam logic [15:0] SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [31:0] LAST_IDX = 32'(TEST_NUM - 1);

  state_e                state_q, state_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic                  rdy_q, rdy_d;
  logic                  err_q, err_d;
  logic [31:0]           rx_cnt_q, rx_cnt_d;
  logic [15:0]           err_cnt_q, err_cnt_d;
  logic [31:0]           fidx_q, fidx_d;
  logic [DATA_WIDTH-1:0] fdata_q, fdata_d;

  logic hs, start, mismatch, fb;

  // rdy_q is only ever set while in S_RUN, so hs needs no state qualifier.
  assign hs       = s_valid & rdy_q;
  assign start    = (state_q == S_IDLE) & i_run;
  assign mismatch = s_data != DATA_WIDTH'(rx_cnt_q);
  assign fb       = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_run) state_d = S_RUN;
      S_RUN:   if (hs && rx_cnt_q == LAST_IDX) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lfsr_d    = lfsr_q;
    err_d     = err_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    fidx_d    = fidx_q;
    fdata_d   = fdata_q;
    if (start) begin
      lfsr_d    = SEED;
      err_d     = 1'b0;
      rx_cnt_d  = '0;
      err_cnt_d = '0;
      fidx_d    = '0;
      fdata_d   = '0;
    end else begin
      if (state_d == S_RUN) lfsr_d = {lfsr_q[14:0], fb};
      if (hs) begin
        rx_cnt_d = rx_cnt_q + 32'd1;
        if (mismatch) begin
          err_d = 1'b1;
          if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
          if (!err_q) begin
            fidx_d  = rx_cnt_q;
            fdata_d = s_data;
          end
        end
      end
    end
    // Ready follows the value being loaded into the LFSR, so the first RUN
    // cycle already uses the freshly seeded bit.
    rdy_d = (state_d == S_RUN) ? (READY_MODE ? lfsr_d[0] : 1'b1) : 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      fidx_q    <= '0;
      fdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      fidx_q    <= fidx_d;
      fdata_q   <= fdata_d;
    end
  end

  assign s_ready          = rdy_q;
  assign o_busy           = (state_q == S_RUN);
  assign o_done           = (state_q == S_DONE);
  assign o_err            = err_q;
  assign o_rx_cnt         = rx_cnt_q;
  assign o_err_cnt        = err_cnt_q;
  assign o_first_err_idx  = fidx_q;
  assign o_first_err_data = fdata_q;

endmodule

// File: tb/tb_kim_stream_checker.sv
// Directed bench: three checker instances (constant ready, LFSR ready,
// single-beat run) driven through a linear sequence of steps.
module tb_kim_stream_checker;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // dut0: READY_MODE=0, TEST_NUM=16
  logic        run0 = 0, valid0 = 0, rdy0, busy0, done0, err0;
  logic [31:0] data0 = 0, rx0, fidx0, fdata0;
  logic [15:0] ecnt0;
  // dut1: READY_MODE=1, TEST_NUM=16
  logic        run1 = 0, valid1 = 0, rdy1, busy1, done1, err1;
  logic [31:0] data1 = 0, rx1, fidx1, fdata1;
  logic [15:0] ecnt1;
  // dut2: READY_MODE=0, TEST_NUM=1
  logic        run2 = 0, valid2 = 0, rdy2, busy2, done2, err2;
  logic [31:0] data2 = 0, rx2, fidx2, fdata2;
  logic [15:0] ecnt2;

  kim_stream_checker #(.DATA_WIDTH(32), .TEST_NUM(16), .READY_MODE(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .i_run(run0), .s_valid(valid0), .s_ready(rdy0),
    .s_data(data0), .o_busy(busy0), .o_done(done0), .o_err(err0), .o_rx_cnt(rx0),
    .o_err_cnt(ecnt0), .o_first_err_idx(fidx0), .o_first_err_data(fdata0));
  kim_stream_checker #(.DATA_WIDTH(32), .TEST_NUM(16), .READY_MODE(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .i_run(run1), .s_valid(valid1), .s_ready(rdy1),
    .s_data(data1), .o_busy(busy1), .o_done(done1), .o_err(err1), .o_rx_cnt(rx1),
    .o_err_cnt(ecnt1), .o_first_err_idx(fidx1), .o_first_err_data(fdata1));
  kim_stream_checker #(.DATA_WIDTH(32), .TEST_NUM(1), .READY_MODE(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .i_run(run2), .s_valid(valid2), .s_ready(rdy2),
    .s_data(data2), .o_busy(busy2), .o_done(done2), .o_err(err2), .o_rx_cnt(rx2),
    .o_err_cnt(ecnt2), .o_first_err_idx(fidx2), .o_first_err_data(fdata2));

  int done_pulses;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One beat on dut0; ready is constant during a run so every call is a handshake.
  task automatic beat0(input logic [31:0] d);
    data0  = d;
    valid0 = 1'b1;
    step();
    if (done0) done_pulses++;
  endtask

  task automatic start0();
    run0 = 1'b1;
    valid0 = 1'b1;
    data0 = 32'd0;
    step();
    run0 = 1'b0;
    chk("start_busy", 64'(busy0), 64'd1);
    chk("start_ready", 64'(rdy0), 64'd1);
    done_pulses = 0;
  endtask

  initial begin
    // ---------------- reset state
    #12;
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_err", 64'(err0), 64'd0);
    chk("rst_rx", 64'(rx0), 64'd0);
    chk("rst_ecnt", 64'(ecnt0), 64'd0);
    rst_n = 1'b1;
    step();

    // ---------------- run A: mismatches at beats 5 (99) and 9 (77)
    start0();
    for (int i = 0; i < 16; i++) begin
      beat0((i == 5) ? 32'd99 : (i == 9) ? 32'd77 : 32'(i));
      if (i == 5) chk("a_err_after5", 64'(err0), 64'd1);
      if (i == 4) chk("a_noerr_before5", 64'(err0), 64'd0);
    end
    chk("a_done", 64'(done0), 64'd1);
    chk("a_pulses", 64'(done_pulses), 64'd1);
    chk("a_err", 64'(err0), 64'd1);
    chk("a_ecnt", 64'(ecnt0), 64'd2);
    chk("a_fidx", 64'(fidx0), 64'd5);
    chk("a_fdata", 64'(fdata0), 64'd99);
    chk("a_rx", 64'(rx0), 64'd16);
    chk("a_ready_end", 64'(rdy0), 64'd0);
    chk("a_busy_end", 64'(busy0), 64'd0);

    // i_run during S_DONE is ignored; the next IDLE cycle starts run B
    run0 = 1'b1;
    step();
    chk("b_ign_busy", 64'(busy0), 64'd0);
    chk("b_ign_done", 64'(done0), 64'd0);
    chk("b_hold_ecnt", 64'(ecnt0), 64'd2);
    step();
    run0 = 1'b0;
    chk("b_busy", 64'(busy0), 64'd1);
    chk("b_clr_rx", 64'(rx0), 64'd0);
    chk("b_clr_err", 64'(err0), 64'd0);
    chk("b_clr_ecnt", 64'(ecnt0), 64'd0);
    chk("b_clr_fidx", 64'(fidx0), 64'd0);
    chk("b_clr_fdata", 64'(fdata0), 64'd0);

    // ---------------- run B: clean, with i_run pulsed mid-run
    done_pulses = 0;
    for (int i = 0; i < 16; i++) begin
      run0 = (i == 3);
      beat0(32'(i));
      if (i == 3) chk("b_midrun_rx", 64'(rx0), 64'd4);
      if (i == 7) chk("b_midrun_busy", 64'(busy0), 64'd1);
    end
    run0 = 1'b0;
    chk("b_pulses", 64'(done_pulses), 64'd1);
    chk("b_rx", 64'(rx0), 64'd16);
    chk("b_err", 64'(err0), 64'd0);
    chk("b_ecnt", 64'(ecnt0), 64'd0);
    step();
    chk("b_done_clr", 64'(done0), 64'd0);
    chk("b_rx_hold", 64'(rx0), 64'd16);
    valid0 = 1'b0;
    step();

    // ---------------- run C: reset after 7 beats (beat 3 wrong)
    start0();
    for (int i = 0; i < 7; i++) beat0((i == 3) ? 32'd50 : 32'(i));
    chk("c_rx7", 64'(rx0), 64'd7);
    chk("c_err", 64'(err0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("c_rst_busy", 64'(busy0), 64'd0);
    chk("c_rst_ready", 64'(rdy0), 64'd0);
    chk("c_rst_rx", 64'(rx0), 64'd0);
    chk("c_rst_err", 64'(err0), 64'd0);
    chk("c_rst_ecnt", 64'(ecnt0), 64'd0);
    chk("c_rst_fidx", 64'(fidx0), 64'd0);
    chk("c_rst_fdata", 64'(fdata0), 64'd0);
    done_pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (done0) done_pulses++;
    end
    rst_n = 1'b1;
    step();
    if (done0) done_pulses++;
    chk("c_no_done", 64'(done_pulses), 64'd0);

    // ---------------- run D: clean 16-beat run after reset
    start0();
    for (int i = 0; i < 16; i++) beat0(32'(i));
    chk("d_pulses", 64'(done_pulses), 64'd1);
    chk("d_rx", 64'(rx0), 64'd16);
    chk("d_err", 64'(err0), 64'd0);
    valid0 = 1'b0;
    step();

    // ---------------- dut1: LFSR backpressure, random valid
    begin
      int idx = 0;
      int cyc = 0;
      bit seen0 = 0, seen1 = 0, got_done = 0;
      logic r, v;
      run1 = 1'b1;
      step();
      run1 = 1'b0;
      chk("m1_busy", 64'(busy1), 64'd1);
      while (!got_done && cyc < 2000) begin
        if (!(valid1 && !rdy1)) valid1 = ($urandom_range(0, 1) == 1);
        data1 = 32'(idx);
        if (busy1) begin
          if (rdy1) seen1 = 1; else seen0 = 1;
        end
        r = rdy1;
        v = valid1;
        step();
        cyc++;
        if (r && v) idx++;
        if (done1) got_done = 1;
      end
      valid1 = 1'b0;
      chk("m1_done_seen", 64'(got_done), 64'd1);
      chk("m1_rx", 64'(rx1), 64'd16);
      chk("m1_src_idx", 64'(idx), 64'd16);
      chk("m1_err", 64'(err1), 64'd0);
      chk("m1_ready_lo", 64'(seen0), 64'd1);
      chk("m1_ready_hi", 64'(seen1), 64'd1);
    end
    step();

    // ---------------- dut2: TEST_NUM=1, valid held high
    run2 = 1'b1;
    valid2 = 1'b1;
    data2 = 32'd0;
    step();
    run2 = 1'b0;
    chk("t1_ready", 64'(rdy2), 64'd1);
    chk("t1_rx0", 64'(rx2), 64'd0);
    step();
    chk("t1_done", 64'(done2), 64'd1);
    chk("t1_ready_off", 64'(rdy2), 64'd0);
    chk("t1_rx1", 64'(rx2), 64'd1);
    step();
    chk("t1_done_clr", 64'(done2), 64'd0);
    chk("t1_rx_hold", 64'(rx2), 64'd1);
    chk("t1_busy", 64'(busy2), 64'd0);
    chk("t1_err", 64'(err2), 64'd0);
    valid2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
